// File: rtl/aesha_job_arbiter_if.sv
// aesha_job_arbiter_if: requester job/response handshakes and engine launch
// signals that connect the AESHA job arbiter to its environment.
interface aesha_job_arbiter_if;
    logic         req0_valid;
    logic         req0_ready;
    logic         req0_aes_or_keccak;
    logic         req0_enc_or_dec;
    logic [127:0] req0_key;
    logic [511:0] req0_data;

    logic         req1_valid;
    logic         req1_ready;
    logic         req1_aes_or_keccak;
    logic         req1_enc_or_dec;
    logic [127:0] req1_key;
    logic [511:0] req1_data;

    logic         rsp0_valid;
    logic         rsp0_ready;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [511:0] rsp_data;
    logic         rsp_err;

    logic         eng_start;
    logic         eng_aes_or_keccak;
    logic         eng_enc_or_dec;
    logic [127:0] eng_key;
    logic [511:0] eng_data;
    logic         eng_done;
    logic [511:0] eng_result;

    logic         busy;
    logic [7:0]   timeout_cnt;

    // Arbiter side: takes jobs and engine completions, drives grants,
    // responses and the engine launch.
    modport slave (
        input  req0_valid, req0_aes_or_keccak, req0_enc_or_dec, req0_key, req0_data,
        input  req1_valid, req1_aes_or_keccak, req1_enc_or_dec, req1_key, req1_data,
        input  rsp0_ready, rsp1_ready,
        input  eng_done, eng_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        output eng_start, eng_aes_or_keccak, eng_enc_or_dec, eng_key, eng_data,
        output busy, timeout_cnt
    );

    // Environment side: requesters plus the engine.
    modport master (
        output req0_valid, req0_aes_or_keccak, req0_enc_or_dec, req0_key, req0_data,
        output req1_valid, req1_aes_or_keccak, req1_enc_or_dec, req1_key, req1_data,
        output rsp0_ready, rsp1_ready,
        output eng_done, eng_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        input  eng_start, eng_aes_or_keccak, eng_enc_or_dec, eng_key, eng_data,
        input  busy, timeout_cnt
    );
endinterface

// File: rtl/aesha_job_arbiter.sv
// aesha_job_arbiter: shares one AESHA engine between two requesters.
// One job at a time, round-robin on ties, watchdog-guarded completion,
// and the result is returned only to the requester that owns the job.
module aesha_job_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    aesha_job_arbiter_if.slave bus
);
    localparam int WDOG_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    logic                last_grant;
    logic                owner;
    logic                job_aes;
    logic                job_enc;
    logic [127:0]        job_key;
    logic [511:0]        job_data;
    logic [511:0]        result;
    logic                result_err;
    logic [WDOG_W-1:0]   wdog;
    logic [7:0]          aborts;
    logic                grant0;
    logic                grant1;
    logic                owner_ready;

    // Grant selection: a lone valid wins, a tie goes to whoever did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
    end

    assign owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

    // Job FSM: accept, launch, wait under the watchdog, then hold the response for the owner.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            job_aes    <= 1'b0;
            job_enc    <= 1'b0;
            job_key    <= '0;
            job_data   <= '0;
            result     <= '0;
            result_err <= 1'b0;
            wdog       <= '0;
            aborts     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner    <= grant1;
                        job_aes  <= grant1 ? bus.req1_aes_or_keccak : bus.req0_aes_or_keccak;
                        job_enc  <= grant1 ? bus.req1_enc_or_dec    : bus.req0_enc_or_dec;
                        job_key  <= grant1 ? bus.req1_key           : bus.req0_key;
                        job_data <= grant1 ? bus.req1_data          : bus.req0_data;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.eng_done) begin
                        result     <= bus.eng_result;
                        result_err <= 1'b0;
                        state      <= RESP;
                    end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                        result     <= '0;
                        result_err <= 1'b1;
                        if (aborts != 8'hFF) begin
                            aborts <= aborts + 8'd1;
                        end
                        state      <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready        = (state == IDLE) && i_reset && grant0;
    assign bus.req1_ready        = (state == IDLE) && i_reset && grant1;
    assign bus.rsp0_valid        = (state == RESP) && !owner;
    assign bus.rsp1_valid        = (state == RESP) && owner;
    assign bus.rsp_data          = result;
    assign bus.rsp_err           = result_err;
    assign bus.eng_start         = (state == ISSUE);
    assign bus.eng_aes_or_keccak = job_aes;
    assign bus.eng_enc_or_dec    = job_enc;
    assign bus.eng_key           = job_key;
    assign bus.eng_data          = job_data;
    assign bus.busy              = (state != IDLE);
    assign bus.timeout_cnt       = aborts;
endmodule

// File: tb/tb_aesha_job_arbiter.sv
// tb_aesha_job_arbiter: scenario tasks for the AESHA job arbiter with a
// scoreboard of expected responses pushed at job acceptance.
module tb_aesha_job_arbiter;
    localparam int TIMEOUT = 64;

    typedef struct {
        int           owner;
        logic [511:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_timeouts = 0;

    aesha_job_arbiter_if ifc();

    aesha_job_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (ifc.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [511:0] eng_model(input logic [127:0] key, input logic [511:0] data);
        return data ^ {4{key}} ^ 512'h5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ifc.req0_valid = 1'b0; ifc.req0_aes_or_keccak = 1'b0; ifc.req0_enc_or_dec = 1'b0;
        ifc.req0_key = '0; ifc.req0_data = '0;
        ifc.req1_valid = 1'b0; ifc.req1_aes_or_keccak = 1'b0; ifc.req1_enc_or_dec = 1'b0;
        ifc.req1_key = '0; ifc.req1_data = '0;
        ifc.rsp0_ready = 1'b0; ifc.rsp1_ready = 1'b0;
        ifc.eng_done = 1'b0; ifc.eng_result = '0;
    endtask

    task automatic drive_req(input int r, input logic aes, input logic enc,
                             input logic [127:0] key, input logic [511:0] data);
        if (r == 0) begin
            ifc.req0_valid = 1'b1; ifc.req0_aes_or_keccak = aes; ifc.req0_enc_or_dec = enc;
            ifc.req0_key = key; ifc.req0_data = data;
        end else begin
            ifc.req1_valid = 1'b1; ifc.req1_aes_or_keccak = aes; ifc.req1_enc_or_dec = enc;
            ifc.req1_key = key; ifc.req1_data = data;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
        exp_timeouts = 0;
    endtask

    // Present a job and wait (bounded) until it is accepted; ends in the ISSUE cycle.
    task automatic launch(input int r, input logic aes, input logic enc,
                          input logic [127:0] key, input logic [511:0] data, output bit ok);
        drive_req(r, aes, enc, key, data);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            settle();
            if ((r == 0 && ifc.req0_ready === 1'b1) || (r == 1 && ifc.req1_ready === 1'b1)) ok = 1'b1;
            tick();
        end
        if (r == 0) ifc.req0_valid = 1'b0; else ifc.req1_valid = 1'b0;
    endtask

    // From the ISSUE cycle, pulse done on the given WAIT cycle (1-based).
    task automatic serve(input int wait_cycles, input logic [511:0] res);
        tick();
        for (int i = 1; i < wait_cycles; i++) tick();
        ifc.eng_done = 1'b1;
        ifc.eng_result = res;
        tick();
        ifc.eng_done = 1'b0;
        ifc.eng_result = '0;
    endtask

    task automatic get_rsp(output bit ok, output logic [1:0] v, output logic [511:0] d, output logic e);
        ok = 1'b0;
        for (int i = 0; i < 2 * TIMEOUT + 20 && !ok; i++) begin
            if (ifc.rsp0_valid === 1'b1 || ifc.rsp1_valid === 1'b1) ok = 1'b1;
            else tick();
        end
        v = {ifc.rsp1_valid, ifc.rsp0_valid};
        d = ifc.rsp_data;
        e = ifc.rsp_err;
    endtask

    task automatic release_rsp(input int r);
        if (r == 0) ifc.rsp0_ready = 1'b1; else ifc.rsp1_ready = 1'b1;
        settle();
        tick();
        ifc.rsp0_ready = 1'b0;
        ifc.rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.req0_valid = 1'b1;
        ifc.req1_valid = 1'b1;
        tick();
        tick();
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", ifc.busy); end
        checks++; if (ifc.eng_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got %b exp 0", ifc.eng_start); end
        checks++; if ({ifc.rsp1_valid, ifc.rsp0_valid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b exp 00", {ifc.rsp1_valid, ifc.rsp0_valid}); end
        checks++; if ({ifc.req1_ready, ifc.req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got %b exp 00", {ifc.req1_ready, ifc.req0_ready}); end
        checks++; if (ifc.rsp_data !== 512'd0 || ifc.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp got %h/%b exp 0/0", ifc.rsp_data, ifc.rsp_err); end
        checks++; if (ifc.eng_key !== 128'd0 || ifc.eng_data !== 512'd0) begin errors++; $display("[TB] FAIL reset_operands got %h/%h exp 0/0", ifc.eng_key, ifc.eng_data); end
        checks++; if ({ifc.eng_aes_or_keccak, ifc.eng_enc_or_dec} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mode got %b exp 00", {ifc.eng_aes_or_keccak, ifc.eng_enc_or_dec}); end
        checks++; if (ifc.timeout_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_timeout_cnt got %0d exp 0", ifc.timeout_cnt); end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_job();
        logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
        logic [511:0] data = {16{32'hC0FFEE11}};
        logic [511:0] res;
        exp_t x; logic [1:0] v; logic [511:0] d; logic e; bit ok;
        res = eng_model(key, data);
        drive_req(0, 1'b1, 1'b1, key, data);
        settle();
        checks++; if ({ifc.req1_ready, ifc.req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL single_ready got %b exp 01", {ifc.req1_ready, ifc.req0_ready}); end
        sb.push_back('{owner: 0, data: res, err: 1'b0});
        tick();
        ifc.req0_valid = 1'b0;
        settle();
        checks++; if (ifc.eng_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start got %b exp 1", ifc.eng_start); end
        checks++; if ({ifc.eng_aes_or_keccak, ifc.eng_enc_or_dec} !== 2'b11) begin errors++; $display("[TB] FAIL single_mode got %b exp 11", {ifc.eng_aes_or_keccak, ifc.eng_enc_or_dec}); end
        checks++; if (ifc.eng_key !== key || ifc.eng_data !== data) begin errors++; $display("[TB] FAIL single_operands got %h/%h exp %h/%h", ifc.eng_key, ifc.eng_data, key, data); end
        tick();
        checks++; if (ifc.eng_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_pulse got %b exp 0", ifc.eng_start); end
        for (int i = 1; i < 23; i++) tick();
        ifc.eng_done = 1'b1;
        ifc.eng_result = res;
        tick();
        ifc.eng_done = 1'b0;
        get_rsp(ok, v, d, e);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_rsp_wait got none exp response"); end
        x = sb.pop_front();
        checks++; if (v !== 2'b01) begin errors++; $display("[TB] FAIL single_rsp_valid got %b exp 01", v); end
        checks++; if (d !== x.data || e !== x.err) begin errors++; $display("[TB] FAIL single_rsp got %h/%b exp %h/%b", d, e, x.data, x.err); end
        release_rsp(0);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got busy=%b exp 0", ifc.busy); end
    endtask

    task automatic test_round_robin();
        logic [127:0] k0, k1;
        logic [511:0] d0, d1, res;
        exp_t x; logic [1:0] v; logic [511:0] d; logic e; bit ok;
        int g;
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            k0 = {$urandom, $urandom, $urandom, 32'(j)};
            k1 = {$urandom, $urandom, $urandom, 32'(j + 100)};
            d0 = {16{$urandom}};
            d1 = {16{$urandom}};
            drive_req(0, 1'b1, 1'b0, k0, d0);
            drive_req(1, 1'b0, 1'b1, k1, d1);
            settle();
            g = j % 2;
            checks++; if ({ifc.req1_ready, ifc.req0_ready} !== ((g == 1) ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rr_grant%0d got %b exp owner %0d", j, {ifc.req1_ready, ifc.req0_ready}, g); end
            res = (g == 1) ? eng_model(k1, d1) : eng_model(k0, d0);
            sb.push_back('{owner: g, data: res, err: 1'b0});
            tick();
            checks++; if (ifc.eng_start !== 1'b1 || ifc.eng_key !== ((g == 1) ? k1 : k0) || ifc.eng_data !== ((g == 1) ? d1 : d0)) begin errors++; $display("[TB] FAIL rr_launch%0d got start=%b key=%h exp key=%h", j, ifc.eng_start, ifc.eng_key, (g == 1) ? k1 : k0); end
            serve(3 + j, res);
            get_rsp(ok, v, d, e);
            x = sb.pop_front();
            checks++; if (!ok || v !== ((x.owner == 1) ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rr_rsp_valid%0d got %b exp owner %0d", j, v, x.owner); end
            checks++; if (d !== x.data || e !== x.err) begin errors++; $display("[TB] FAIL rr_rsp%0d got %h/%b exp %h/%b", j, d, e, x.data, x.err); end
            release_rsp(g);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic [127:0] k = 128'hFEEDFACE_0BADF00D_12345678_9ABCDEF0;
        logic [511:0] dd = {8{64'h0123456789ABCDEF}};
        logic [511:0] res;
        exp_t x; logic [1:0] v; logic [511:0] d; logic e; bit ok;
        int n;
        apply_reset();
        sb.push_back('{owner: 1, data: 512'd0, err: 1'b1});
        launch(1, 1'b0, 1'b0, k, dd, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL to_accept got none exp accept"); end
        tick();
        n = 0;
        while (!(ifc.rsp0_valid === 1'b1 || ifc.rsp1_valid === 1'b1) && n < TIMEOUT + 20) begin
            tick();
            n++;
        end
        checks++; if (n != TIMEOUT) begin errors++; $display("[TB] FAIL to_wait_cycles got %0d exp %0d", n, TIMEOUT); end
        exp_timeouts++;
        get_rsp(ok, v, d, e);
        x = sb.pop_front();
        checks++; if (!ok || v !== 2'b10) begin errors++; $display("[TB] FAIL to_rsp_valid got %b exp 10", v); end
        checks++; if (d !== x.data || e !== x.err) begin errors++; $display("[TB] FAIL to_rsp got %h/%b exp %h/%b", d, e, x.data, x.err); end
        checks++; if (ifc.timeout_cnt !== 8'(exp_timeouts)) begin errors++; $display("[TB] FAIL to_count got %0d exp %0d", ifc.timeout_cnt, exp_timeouts); end
        release_rsp(1);
        res = eng_model(k, dd);
        sb.push_back('{owner: 0, data: res, err: 1'b0});
        launch(0, 1'b1, 1'b0, k, dd, ok);
        serve(5, res);
        get_rsp(ok, v, d, e);
        x = sb.pop_front();
        checks++; if (!ok || v !== 2'b01 || d !== x.data || e !== x.err) begin errors++; $display("[TB] FAIL to_after_rsp got %b %h/%b exp 01 %h/%b", v, d, e, x.data, x.err); end
        checks++; if (ifc.timeout_cnt !== 8'(exp_timeouts)) begin errors++; $display("[TB] FAIL to_after_count got %0d exp %0d", ifc.timeout_cnt, exp_timeouts); end
        release_rsp(0);
    endtask

    task automatic test_spurious_done();
        logic [127:0] k = 128'h11112222333344445555666677778888;
        logic [511:0] dd = {16{32'h600DCAFE}};
        logic [511:0] res;
        exp_t x; logic [1:0] v; logic [511:0] d; logic e; bit ok;
        ifc.eng_done = 1'b1;
        ifc.eng_result = {16{32'hDEADBEEF}};
        tick();
        ifc.eng_done = 1'b0;
        tick();
        checks++; if (ifc.busy !== 1'b0 || {ifc.rsp1_valid, ifc.rsp0_valid} !== 2'b00) begin errors++; $display("[TB] FAIL spur_idle got busy=%b valid=%b exp 0/00", ifc.busy, {ifc.rsp1_valid, ifc.rsp0_valid}); end
        res = eng_model(k, dd);
        sb.push_back('{owner: 1, data: res, err: 1'b0});
        launch(1, 1'b1, 1'b1, k, dd, ok);
        serve(4, res);
        get_rsp(ok, v, d, e);
        ifc.eng_done = 1'b1;
        ifc.eng_result = {16{32'hBAADBAAD}};
        tick();
        tick();
        ifc.eng_done = 1'b0;
        x = sb.pop_front();
        checks++; if ({ifc.rsp1_valid, ifc.rsp0_valid} !== 2'b10) begin errors++; $display("[TB] FAIL spur_resp_valid got %b exp 10", {ifc.rsp1_valid, ifc.rsp0_valid}); end
        checks++; if (ifc.rsp_data !== x.data || ifc.rsp_err !== x.err) begin errors++; $display("[TB] FAIL spur_resp_data got %h/%b exp %h/%b", ifc.rsp_data, ifc.rsp_err, x.data, x.err); end
        release_rsp(1);
    endtask

    task automatic test_done_at_threshold();
        logic [127:0] k = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
        logic [511:0] dd = {16{32'h13579BDF}};
        logic [511:0] res;
        exp_t x; logic [1:0] v; logic [511:0] d; logic e; bit ok;
        res = eng_model(k, dd);
        sb.push_back('{owner: 0, data: res, err: 1'b0});
        launch(0, 1'b0, 1'b1, k, dd, ok);
        serve(TIMEOUT, res);
        get_rsp(ok, v, d, e);
        x = sb.pop_front();
        checks++; if (!ok || v !== 2'b01) begin errors++; $display("[TB] FAIL thr_rsp_valid got %b exp 01", v); end
        checks++; if (d !== x.data || e !== x.err) begin errors++; $display("[TB] FAIL thr_rsp got %h/%b exp %h/%b", d, e, x.data, x.err); end
        checks++; if (ifc.timeout_cnt !== 8'(exp_timeouts)) begin errors++; $display("[TB] FAIL thr_count got %0d exp %0d", ifc.timeout_cnt, exp_timeouts); end
        release_rsp(0);
    endtask

    task automatic test_reset_mid_job();
        logic [127:0] k = 128'h0F0E0D0C0B0A09080706050403020100;
        logic [511:0] dd = {16{32'h89ABCDEF}};
        logic [511:0] res;
        exp_t x; logic [1:0] v; logic [511:0] d; logic e; bit ok, seen;
        sb.push_back('{owner: 0, data: eng_model(k, dd), err: 1'b0});
        launch(0, 1'b1, 1'b1, k, dd, ok);
        tick();
        tick();
        tick();
        drive_req(1, 1'b1, 1'b0, k, dd);
        rst_n = 1'b0;
        tick();
        sb.delete();
        exp_timeouts = 0;
        checks++; if (ifc.busy !== 1'b0 || ifc.eng_start !== 1'b0 || {ifc.rsp1_valid, ifc.rsp0_valid} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_ctrl got busy=%b start=%b valid=%b exp 0/0/00", ifc.busy, ifc.eng_start, {ifc.rsp1_valid, ifc.rsp0_valid}); end
        checks++; if (ifc.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready got %b exp 0", ifc.req1_ready); end
        checks++; if (ifc.eng_key !== 128'd0 || ifc.eng_data !== 512'd0 || ifc.rsp_data !== 512'd0 || ifc.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_regs got key=%h err=%b exp 0/0", ifc.eng_key, ifc.rsp_err); end
        checks++; if (ifc.timeout_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset_count got %0d exp 0", ifc.timeout_cnt); end
        ifc.req1_valid = 1'b0;
        rst_n = 1'b1;
        ifc.eng_done = 1'b1;
        ifc.eng_result = {16{32'hFACEFACE}};
        tick();
        ifc.eng_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ifc.eng_start !== 1'b0 || ifc.busy !== 1'b0 || ifc.rsp0_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL mid_late_done got activity exp idle"); end
        res = eng_model(k ^ 128'h1, dd);
        sb.push_back('{owner: 1, data: res, err: 1'b0});
        launch(1, 1'b0, 1'b0, k ^ 128'h1, dd, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_new_accept got none exp accept"); end
        serve(7, res);
        get_rsp(ok, v, d, e);
        x = sb.pop_front();
        checks++; if (!ok || v !== 2'b10 || d !== x.data || e !== x.err) begin errors++; $display("[TB] FAIL mid_new_rsp got %b %h/%b exp 10 %h/%b", v, d, e, x.data, x.err); end
        release_rsp(1);
    endtask

    task automatic test_back_to_back();
        logic [127:0] k0 = 128'hCAFEBABE_CAFEBABE_CAFEBABE_CAFEBABE;
        logic [127:0] k1 = 128'h0DDBA11_00000000_FFFFFFFF_12121212;
        logic [511:0] d0 = {16{32'h0000FFFF}};
        logic [511:0] d1 = {16{32'hFFFF0000}};
        logic [511:0] res;
        exp_t x; logic [1:0] v; logic [511:0] d; logic e; bit ok;
        res = eng_model(k0, d0);
        sb.push_back('{owner: 0, data: res, err: 1'b0});
        launch(0, 1'b1, 1'b0, k0, d0, ok);
        serve(6, res);
        get_rsp(ok, v, d, e);
        x = sb.pop_front();
        drive_req(1, 1'b1, 1'b1, k1, d1);
        ifc.rsp1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            checks++; if ({ifc.rsp1_valid, ifc.rsp0_valid} !== 2'b01 || ifc.rsp_data !== x.data || ifc.rsp_err !== x.err || ifc.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold%0d got valid=%b rdy1=%b data=%h exp 01/0/%h", i, {ifc.rsp1_valid, ifc.rsp0_valid}, ifc.req1_ready, ifc.rsp_data, x.data); end
            tick();
        end
        ifc.rsp1_ready = 1'b0;
        release_rsp(0);
        settle();
        checks++; if (ifc.req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_next_grant got %b exp 1", ifc.req1_ready); end
        res = eng_model(k1, d1);
        sb.push_back('{owner: 1, data: res, err: 1'b0});
        launch(1, 1'b1, 1'b1, k1, d1, ok);
        checks++; if (ifc.eng_key !== k1 || ifc.eng_data !== d1) begin errors++; $display("[TB] FAIL hold_next_operands got %h exp %h", ifc.eng_key, k1); end
        serve(2, res);
        get_rsp(ok, v, d, e);
        x = sb.pop_front();
        checks++; if (!ok || v !== 2'b10 || d !== x.data || e !== x.err) begin errors++; $display("[TB] FAIL hold_next_rsp got %b %h/%b exp 10 %h/%b", v, d, e, x.data, x.err); end
        release_rsp(1);
    endtask

    // Scenario sequence and summary.
    initial begin
        idle_inputs();
        test_reset();
        test_single_job();
        test_round_robin();
        test_timeout();
        test_spurious_done();
        test_done_at_threshold();
        test_reset_mid_job();
        test_back_to_back();
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so a stuck run still ends.
    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL global_timeout got stuck exp finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] global time limit");
    end
endmodule

// File: doc/aesha_job_arbiter.md
# aesha_job_arbiter

Shares the single AESHA engine (control unit plus AES/Keccak datapath) between two job requesters, e.g. the host register port (requester 0) and the DMA front end (requester 1). It accepts one job at a time with round-robin arbitration and launches it on the engine. It waits for completion under a watchdog, then returns the result to the requester that owns the job. It sits between the requester interfaces and the engine's configuration/start inputs.

## Interface
Parameters:
- TIMEOUT, 64, number of WAIT cycles allowed before a job is aborted (≥2)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_req0_valid / i_req1_valid  in  1  requester has a job presented
- o_req0_ready / o_req1_ready  out  1  job accepted this cycle (valid & ready)
- i_reqN_aes_or_keccak  in  1  per requester: 1 = AES, 0 = Keccak
- i_reqN_enc_or_dec  in  1  per requester: AES direction
- i_reqN_key  in  128  per requester key
- i_reqN_data  in  512  per requester data block
- o_rsp0_valid / o_rsp1_valid  out  1  result available for that requester
- i_rsp0_ready / i_rsp1_ready  in  1  requester consumes result
- o_rsp_data  out  512  result (shared, qualified by o_rspN_valid)
- o_rsp_err  out  1  result aborted by timeout (shared, qualified)
- o_eng_start  out  1  one-cycle engine launch pulse
- o_eng_aes_or_keccak, o_eng_enc_or_dec  out  1  latched job mode
- o_eng_key  out  128; o_eng_data  out  512  latched job operands
- i_eng_done  in  1  one-cycle engine completion pulse
- i_eng_result  in  512  valid in the i_eng_done cycle
- o_busy  out  1  high in every state except IDLE
- o_timeout_cnt  out  8  saturating count of aborted jobs

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If exactly one valid is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - o_reqN_ready is combinational and high only for the granted requester, only in IDLE, only while i_reset = 1.
  - On acceptance, latch mode, key and data into the engine registers and record the owner. Next state: ISSUE.
- ISSUE: o_eng_start = 1 for exactly this cycle; clear the watchdog counter. Next state: WAIT.
- WAIT
  - Increment the watchdog each cycle.
  - If i_eng_done = 1: capture i_eng_result into the response register, err = 0, go to RESP.
  - Else, if the watchdog reaches TIMEOUT−1: response = 0, err = 1, increment o_timeout_cnt (saturates at 255), go to RESP.
  - If done and the timeout threshold occur in the same cycle, done wins.
- RESP
  - o_rspN_valid = 1 for the owner only. o_rsp_data and o_rsp_err are held stable.
  - When i_rspN_ready = 1 for the owner: last_grant ← owner, go to IDLE.
  - i_rsp ready from the non-owner is ignored.
- i_eng_done outside WAIT is ignored.
- Engine operand and mode outputs are held from ISSUE until the next acceptance.
- Requester inputs are sampled only at the acceptance cycle. A valid dropped before a grant carries no obligation.

## Timing
- Reset (i_reset = 0 at a clock edge):
  - state = IDLE, last_grant = 1 (so requester 0 wins the first tie).
  - All o_req*_ready, o_rsp*_valid, o_eng_start, o_busy = 0.
  - o_rsp_data = 0, o_rsp_err = 0, engine operand/mode outputs = 0, o_timeout_cnt = 0.
- Reset mid-job: the job is discarded, no response is issued, o_eng_start is never reasserted for it.
- Acceptance at edge T → o_eng_start high in cycle T+1 → WAIT from T+2.
- Done seen in cycle D → o_rspN_valid high from D+1.
- Response consumed at edge R → IDLE in R+1. The earliest next acceptance is at R+1 (one idle cycle per job).
- Timeout: with no done, the abort occurs on the TIMEOUT-th WAIT cycle; o_rspN_valid rises on the following cycle.
- At most one job is outstanding; no queueing.

## Test plan
- Single job from requester 0 (AES, enc, key=0x000102…0F, data=K): ready for 1 cycle; o_eng_start exactly one cycle later with matching operands; done after 23 cycles with result=R → o_rsp0_valid with data=R, err=0; o_rsp1_valid stays 0.
- Both valid continuously for 4 jobs after reset → grant order 0,1,0,1; each engine launch carries the granted requester's key/data.
- Engine never completes, TIMEOUT=64 → o_rsp_valid after 64 WAIT cycles with data=0, err=1, o_timeout_cnt=1; a subsequent normal job completes with err=0.
- Spurious i_eng_done in IDLE and in RESP → no state change; done coinciding with the timeout threshold → err=0, result captured, o_timeout_cnt unchanged.
- i_reset low for one cycle during WAIT → all outputs at reset values next cycle; the late i_eng_done is ignored; a new job is accepted normally.
- Owner holds i_rsp_ready low for 10 cycles while the other requester is valid → response stays stable, no new grant until the owner consumes it.
